// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module  : img_pkg
// Brief   : Shared types and constants for the result-image dump reader:
//           FSM state enum, default geometry, and the PGM header ROM.
// Revision: 1.0 - initial release
// ============================================================================
package img_pkg;

  // Dump reader FSM states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int IMG_W_DEF     = 352;
  localparam int IMG_H_DEF     = 288;
  localparam int BASE_ADDR_DEF = 25344;
  localparam int ADDR_W_DEF    = 16;
  localparam int PIX_PER_WORD  = 4;

  // Binary PGM header; the first character sits in the most significant byte
  localparam int                  HDR_LEN = 15;
  localparam logic [HDR_LEN*8-1:0] HDR_ROM = "P5\n352 288\n255\n";

  // Header byte by stream position (0 = 'P'); out-of-range positions read 0
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    if (int'(idx) < HDR_LEN) begin
      hdr_byte = HDR_ROM[(HDR_LEN - 1 - int'(idx)) * 8 +: 8];
    end else begin
      hdr_byte = 8'h00;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_fifo2.sv
`default_nettype none
// ============================================================================
// Module  : word_fifo2
// Brief   : Two-entry 32-bit FIFO with push/pop and occupancy count.
//           Head is presented combinationally; push on full is accepted only
//           when a pop frees a slot in the same cycle, pop on empty is ignored.
// Revision: 1.0 - initial release
// ============================================================================
module word_fifo2 (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic [1:0]  occupancy
);

  logic [31:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_occ;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_pop  = pop && (r_occ != 2'd0);
  assign w_do_push = push && ((r_occ != 2'd2) || w_do_pop);
  assign head      = r_mem[r_rd_ptr];
  assign occupancy = r_occ;

  // Storage write; no reset needed since occupancy guards every read
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/img_dump_reader.sv
`default_nettype none
// ============================================================================
// Module  : img_dump_reader
// Brief   : Walks the result-image region of the 32-bit word memory after the
//           accelerator finishes and streams it out as 8-bit pixels with
//           SOF/EOL/EOF flags over a valid/ready handshake. Two-word prefetch
//           buffer sustains one pixel per cycle.
//           Optional macro PGM_HEADER_EN prepends a 15-byte binary PGM header.
// Revision: 1.0 - initial release
// ============================================================================
module img_dump_reader
  import img_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              we,
  input  logic [31:0]       dataR,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int N_WORDS = IMG_W * IMG_H / PIX_PER_WORD;
  localparam int WCNT_W  = $clog2(N_WORDS + 1);
  localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [WCNT_W-1:0] r_words;
  logic [ADDR_W-1:0] r_addr_last;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              r_pend;
  logic [1:0]        r_sub;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [31:0]       w_head;
  logic [1:0]        w_occ;
  logic [1:0]        w_inflight;
  logic              w_fetch_ok;
  logic              w_xfer;
  logic              w_pop;
  logic              w_start;
  logic              w_last_col;
  logic              w_last_row;
`ifdef PGM_HEADER_EN
  logic [3:0]        r_hidx;
`endif

  assign w_start      = (r_state == ST_IDLE) && dump;
  assign w_last_col   = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row   = (r_row == ROW_W'(IMG_H - 1));
  assign w_xfer       = pix_valid && pix_ready;
  assign w_pop        = (r_state == ST_RUN) && w_xfer && (r_sub == 2'd3);
  assign w_inflight   = w_occ + {1'b0, r_pend};
  assign w_issue_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_words);

  // Read only while a buffer slot is guaranteed free when the data returns
  assign en   = w_fetch_ok && (w_inflight < 2'd2) && (r_words != WCNT_W'(N_WORDS));
  assign addr = en ? w_issue_addr : r_addr_last;
  assign we   = 1'b0;

  word_fifo2 u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (r_pend),
    .push_data (dataR),
    .pop       (w_pop),
    .head      (w_head),
    .occupancy (w_occ)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and stream outputs
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    w_fetch_ok = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = 8'h00;
    pix_sof    = 1'b0;
    pix_eol    = 1'b0;
    pix_eof    = 1'b0;
    case (r_state)
      ST_IDLE: begin
`ifdef PGM_HEADER_EN
        if (dump) w_next = ST_HDR;
`else
        if (dump) w_next = ST_RUN;
`endif
      end
`ifdef PGM_HEADER_EN
      ST_HDR: begin
        busy       = 1'b1;
        w_fetch_ok = 1'b1;
        pix_valid  = 1'b1;
        pix_data   = hdr_byte(r_hidx);
        pix_sof    = (r_hidx == 4'd0);
        if (pix_ready && (r_hidx == 4'(HDR_LEN - 1))) w_next = ST_RUN;
      end
`endif
      ST_RUN: begin
        busy       = 1'b1;
        w_fetch_ok = 1'b1;
        if (w_occ != 2'd0) begin
          pix_valid = 1'b1;
          pix_data  = w_head[{r_sub, 3'b000} +: 8];
`ifndef PGM_HEADER_EN
          pix_sof   = (r_col == '0) && (r_row == '0);
`endif
          pix_eol   = w_last_col;
          pix_eof   = w_last_col && w_last_row;
          if (pix_ready && w_last_col && w_last_row) w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read issue tracking: words issued, in-flight read, last driven address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend      <= 1'b0;
      r_words     <= '0;
      r_addr_last <= '0;
    end else begin
      r_pend <= en;
      if (w_start)  r_words <= '0;
      else if (en)  r_words <= r_words + WCNT_W'(1);
      if (en)       r_addr_last <= w_issue_addr;
    end
  end

  // Pixel position: byte within word, column and row (header index if enabled)
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_sub <= 2'd0;
      r_col <= '0;
      r_row <= '0;
`ifdef PGM_HEADER_EN
      r_hidx <= 4'd0;
`endif
    end else if ((r_state == ST_RUN) && w_xfer) begin
      r_sub <= r_sub + 2'd1;
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
`ifdef PGM_HEADER_EN
    else if ((r_state == ST_HDR) && w_xfer) begin
      r_hidx <= r_hidx + 4'd1;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_img_dump_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_img_dump_reader
// Brief   : Self-checking bench for img_dump_reader on a reduced 352x4 image.
//           A word-memory model answers reads one cycle after en; expected
//           bytes and flags come from an image-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_img_dump_reader;

  localparam int W      = 352;
  localparam int H      = 4;
  localparam int BASE   = 25344;
  localparam int AW     = 16;
  localparam int NPIX   = W * H;
  localparam int NWORDS = NPIX / 4;
`ifdef PGM_HEADER_EN
  localparam int NHDR = 15;
  logic [7:0] hdr_bytes [15] = '{8'h50, 8'h35, 8'h0A, 8'h33, 8'h35, 8'h32, 8'h20,
                                 8'h32, 8'h38, 8'h38, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};
`else
  localparam int NHDR = 0;
`endif
  localparam int NXFER = NPIX + NHDR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dump = 1'b0;
  logic          pix_ready = 1'b0;
  logic [31:0]   dataR = '0;
  logic          busy, done, en, we;
  logic [AW-1:0] addr;
  logic [7:0]    pix_data;
  logic          pix_valid, pix_sof, pix_eol, pix_eof;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [10:0]   exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            xfer_cnt, reads, done_cnt;
  logic [AW-1:0] exp_addr;
  bit            mon_on = 1'b0;
  bit            rand_ready = 1'b0;
  bit            eof_prev, stall_prev, frame_done;
  logic [10:0]   held;

  img_dump_reader #(
    .IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .dump(dump), .busy(busy), .done(done),
    .addr(addr), .en(en), .we(we), .dataR(dataR),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronous word memory: data appears the cycle after en
  initial forever begin
    @(posedge clk);
    if (en) dataR <= mem[addr];
  end

  // Downstream ready: steady 1 or a fair coin per cycle
  initial forever begin
    @(posedge clk);
    #1;
    pix_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic fill_mem();
    for (int i = 0; i < NWORDS; i++) mem[BASE + i] = $urandom;
    mem[BASE] = 32'hDDCCBBAA;
  endtask

  // Reference stream: optional header, then pixels in raster order, LSB first
  task automatic build_expected();
    exp_q.delete();
`ifdef PGM_HEADER_EN
    for (int i = 0; i < NHDR; i++) exp_q.push_back({hdr_bytes[i], (i == 0), 2'b00});
`endif
    for (int p = 0; p < NPIX; p++) begin
      logic [31:0] w;
      logic [7:0]  b;
      logic        s, l, f;
      w = mem[BASE + p / 4];
      b = w[8 * (p % 4) +: 8];
      s = (NHDR == 0) && (p == 0);
      l = ((p % W) == W - 1);
      f = (p == NPIX - 1);
      exp_q.push_back({b, s, l, f});
    end
  endtask

  // Stream and memory-port monitor, sampled on the falling edge
  initial begin : mon
    logic [10:0] e, bus;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        bus = {pix_data, pix_sof, pix_eol, pix_eof};
        check("we_low", we, 0);
        check("done_pulse", done, eof_prev);
        if (done) begin
          done_cnt++;
          frame_done = 1'b1;
        end
        if (en) begin
          check("addr_seq", addr, exp_addr);
          exp_addr++;
          reads++;
        end
        if (stall_prev) begin
          check("hold_valid", pix_valid, 1);
          check("hold_bus", bus, held);
        end
        eof_prev = 1'b0;
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_xfer", xfer_cnt + 1, NXFER);
          end else begin
            e = exp_q.pop_front();
            check("pixel", bus, e);
            eof_prev = e[0];
          end
          xfer_cnt++;
        end
        stall_prev = pix_valid && !pix_ready;
        held = bus;
      end
    end
  end

  task automatic start_frame(input bit refill, input bit rnd);
    if (refill) fill_mem();
    build_expected();
    rand_ready = rnd;
    xfer_cnt   = 0;
    reads      = 0;
    done_cnt   = 0;
    exp_addr   = AW'(BASE);
    eof_prev   = 1'b0;
    stall_prev = 1'b0;
    frame_done = 1'b0;
    @(posedge clk); #1;
    dump   = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    dump = 1'b0;
  endtask

  task automatic wait_done(input bit repulse);
    for (int c = 0; c < 4 * NXFER + 200 && !frame_done; c++) begin
      @(posedge clk); #1;
      dump = repulse && (c == 40 || c == 400);
    end
    dump = 1'b0;
    check("frame_done", frame_done, 1);
  endtask

  task automatic end_checks();
    @(posedge clk); #1;
    check("busy_after", busy, 0);
    check("xfer_count", xfer_cnt, NXFER);
    check("queue_left", exp_q.size(), 0);
    check("read_count", reads, NWORDS);
    check("done_count", done_cnt, 1);
    check("addr_last", addr, BASE + NWORDS - 1);
    repeat (3) @(posedge clk);
    #1;
    check("no_restart", busy, 0);
  endtask

  initial begin
    $display("tb_img_dump_reader start");
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", en, 0);
    check("rst_we", we, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_flags", {pix_sof, pix_eol, pix_eof}, 0);
    check("rst_addr", addr, 0);
    check("rst_data", pix_data, 0);
    reset = 1'b0;

    // Frame with ready held high, including first-transaction latency
    start_frame(1'b1, 1'b0);
    check("busy_first", busy, 1);
`ifdef PGM_HEADER_EN
    check("hdr_valid0", pix_valid, 1);
    check("hdr_byte0", pix_data, 8'h50);
    check("hdr_sof0", pix_sof, 1);
`else
    check("en_first", en, 1);
    check("addr_first", addr, BASE);
    @(posedge clk); #1;
    check("valid_early", pix_valid, 0);
    @(posedge clk); #1;
    check("valid_first", pix_valid, 1);
    check("pix0_data", pix_data, 8'hAA);
    check("pix0_sof", pix_sof, 1);
`endif
    wait_done(1'b0);
    end_checks();

    // Same memory, random backpressure, dump re-pulsed while busy
    start_frame(1'b0, 1'b1);
    wait_done(1'b1);
    end_checks();

    // Reset in the middle of a frame, then a clean restart
    start_frame(1'b1, 1'b0);
    for (int c = 0; c < 5000 && xfer_cnt < 500; c++) @(posedge clk);
    check("reached_500", (xfer_cnt >= 500), 1);
    #1;
    reset  = 1'b1;
    mon_on = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", pix_valid, 0);
    check("mid_rst_en", en, 0);
    for (int c = 0; c < 4; c++) begin
      check("mid_rst_nodone", done, 0);
      @(posedge clk); #1;
    end
    start_frame(1'b1, 1'b1);
    wait_done(1'b0);
    end_checks();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
